// File: rtl/float_pkg.sv
// Shared definitions for the integer-to-float converter: FSM state encoding,
// the exponent bias helper and the reference float field widths.
package float_pkg;

    // Standard single-precision field widths, used as the default format.
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_W     = FP32_EXP_W + FP32_MAN_W + 1;

    // Legal range of the two's-complement input width.
    localparam int INT_W_MIN = 2;
    localparam int INT_W_MAX = 64;

    // Conversion FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        NORMALIZE = 2'd1,
        ROUND     = 2'd2,
        DONE      = 2'd3
    } conv_state_t;

    // IEEE-style exponent bias for an exponent field of exp_w bits.
    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/round_to_nearest_even.sv
// Combinational rounding and packing stage: takes a normalized magnitude
// (leading one already stripped) plus its unbiased exponent and produces the
// packed float, the inexact indication and saturation to infinity.
module round_to_nearest_even
    import float_pkg::*;
#(
    parameter int EXPONENT_WIDTH   = 8,
    parameter int MANTISSA_WIDTH   = 23,
    parameter int INTEGER_WIDTH    = 32,
    parameter int ROUND_TO_NEAREST = 1,
    parameter int CNT_W            = 6
) (
    input  logic                                   sign,
    input  logic [INTEGER_WIDTH-2:0]               frac_bits,
    input  logic [CNT_W-1:0]                       exp_cnt,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
    output logic                                   inexact,
    output logic                                   overflow
);

    localparam int OUT_W  = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    // Fraction padded so that mantissa, guard and at least one sticky bit exist
    // even when the integer has fewer bits than the mantissa.
    localparam int EXT_W  = INTEGER_WIDTH - 1 + MANTISSA_WIDTH + 2;
    // Wide enough to hold exponent count plus carry plus bias without wrapping.
    localparam int BEXP_W = (((EXPONENT_WIDTH + 2) > (CNT_W + 1)) ?
                             (EXPONENT_WIDTH + 2) : (CNT_W + 1)) + 1;
    localparam int BIAS   = exp_bias(EXPONENT_WIDTH);
    localparam logic [BEXP_W-1:0] SAT_LIM = BEXP_W'((1 << EXPONENT_WIDTH) - 1);

    // Round-half-to-even increment decision.
    function automatic logic rne_increment(input logic guard_b, input logic sticky_b,
                                           input logic lsb_b);
        return guard_b & (sticky_b | lsb_b);
    endfunction

    // Signed infinity used when the exponent range is exceeded.
    function automatic logic [OUT_W-1:0] saturated(input logic s);
        return {s, {EXPONENT_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
    endfunction

    logic [EXT_W-1:0]          frac_ext;
    logic [MANTISSA_WIDTH-1:0] mant;
    logic                      guard;
    logic                      sticky;
    logic                      round_up;
    logic [MANTISSA_WIDTH:0]   mant_sum;
    logic                      carry;
    logic [BEXP_W-1:0]         bexp;

    assign frac_ext = {frac_bits, {(MANTISSA_WIDTH + 2){1'b0}}};
    assign mant     = frac_ext[EXT_W-1 -: MANTISSA_WIDTH];
    assign guard    = frac_ext[EXT_W-1-MANTISSA_WIDTH];
    assign sticky   = |frac_ext[EXT_W-MANTISSA_WIDTH-2:0];

    // Mantissa rounding, exponent biasing and overflow saturation.
    always_comb begin
        round_up = (ROUND_TO_NEAREST != 0) ? rne_increment(guard, sticky, mant[0]) : 1'b0;
        mant_sum = {1'b0, mant} + (MANTISSA_WIDTH + 1)'(round_up);
        // A carry out leaves the low mantissa bits at zero and bumps the exponent.
        carry    = mant_sum[MANTISSA_WIDTH];
        bexp     = BEXP_W'(exp_cnt) + BEXP_W'(carry) + BEXP_W'(BIAS);
        inexact  = guard | sticky;
        overflow = 1'b0;
        result   = {sign, bexp[EXPONENT_WIDTH-1:0], mant_sum[MANTISSA_WIDTH-1:0]};
        if (bexp >= SAT_LIM) begin
            result   = saturated(sign);
            overflow = 1'b1;
            inexact  = 1'b1;
        end
    end

endmodule

// File: rtl/int_to_float_converter.sv
// Multi-cycle signed integer to floating-point converter. Captures the
// operand as sign/magnitude, normalizes one bit per cycle, rounds in a single
// combinational stage and holds the registered result until it is consumed.
module int_to_float_converter
    import float_pkg::*;
#(
    parameter int EXPONENT_WIDTH   = FP32_EXP_W,
    parameter int MANTISSA_WIDTH   = FP32_MAN_W,
    parameter int INTEGER_WIDTH    = 32,
    parameter int ROUND_TO_NEAREST = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INTEGER_WIDTH-1:0]               in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
    output logic                                   inexact_flag,
    output logic                                   overflow_flag
);

    localparam int OUT_W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam int CNT_W = $clog2(INTEGER_WIDTH) + 1;

    conv_state_t              state_q, state_d;
    logic                     sign_q, sign_d;
    logic [INTEGER_WIDTH-1:0] mag_q, mag_d;
    logic [CNT_W-1:0]         exp_cnt_q, exp_cnt_d;
    logic [OUT_W-1:0]         out_q, out_d;
    logic                     inexact_q, inexact_d;
    logic                     overflow_q, overflow_d;

    logic [INTEGER_WIDTH-1:0] in_mag;
    logic [OUT_W-1:0]         rnd_result;
    logic                     rnd_inexact;
    logic                     rnd_overflow;

    // Two's-complement magnitude; the most negative value maps to 2^(W-1).
    assign in_mag = in_data[INTEGER_WIDTH-1] ? (~in_data + INTEGER_WIDTH'(1)) : in_data;

    round_to_nearest_even #(
        .EXPONENT_WIDTH  (EXPONENT_WIDTH),
        .MANTISSA_WIDTH  (MANTISSA_WIDTH),
        .INTEGER_WIDTH   (INTEGER_WIDTH),
        .ROUND_TO_NEAREST(ROUND_TO_NEAREST),
        .CNT_W           (CNT_W)
    ) u_round (
        .sign     (sign_q),
        .frac_bits(mag_q[INTEGER_WIDTH-2:0]),
        .exp_cnt  (exp_cnt_q),
        .result   (rnd_result),
        .inexact  (rnd_inexact),
        .overflow (rnd_overflow)
    );

    // Next-state and datapath updates for the capture/normalize/round/done flow.
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        exp_cnt_d  = exp_cnt_q;
        out_d      = out_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d    = in_data[INTEGER_WIDTH-1];
                    mag_d     = in_mag;
                    exp_cnt_d = CNT_W'(INTEGER_WIDTH - 1);
                    if (in_data == '0) begin
                        // Zero has no leading one to find; emit +0 directly.
                        out_d      = '0;
                        inexact_d  = 1'b0;
                        overflow_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        state_d = NORMALIZE;
                    end
                end
            end
            NORMALIZE: begin
                if (mag_q[INTEGER_WIDTH-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d     = mag_q << 1;
                    exp_cnt_d = exp_cnt_q - CNT_W'(1);
                end
            end
            ROUND: begin
                out_d      = rnd_result;
                inexact_d  = rnd_inexact;
                overflow_d = rnd_overflow;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and visible result registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_q      <= '0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            inexact_q  <= inexact_d;
            overflow_q <= overflow_d;
        end
    end

    // Working operand registers; only meaningful once a conversion has started.
    always_ff @(posedge clk) begin
        sign_q    <= sign_d;
        mag_q     <= mag_d;
        exp_cnt_q <= exp_cnt_d;
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign out           = out_q;
    assign inexact_flag  = inexact_q;
    assign overflow_flag = overflow_q;

endmodule

// File: doc/int_to_float_converter.md
INT_TO_FLOAT_CONVERTER -- requirements
Module: int_to_float_converter

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, meaning result exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, meaning result stored-mantissa width (no implicit bit).
REQ-003 SHALL have parameter INTEGER_WIDTH, default 32, meaning two's-complement input width; legal range is 2 to 64.
REQ-004 SHALL have parameter ROUND_TO_NEAREST, default 1, meaning 1 selects round-to-nearest-even and 0 selects truncation.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts in_data.
REQ-009 SHALL have port in_data, input, INTEGER_WIDTH bits: signed integer operand.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port out, output, EXPONENT_WIDTH+MANTISSA_WIDTH+1 bits: {sign, exponent, mantissa}.
REQ-013 SHALL have port inexact_flag, output, 1 bit: the result was rounded or truncated.
REQ-014 SHALL have port overflow_flag, output, 1 bit: the result saturated to infinity.

Function
REQ-015 SHALL implement FSM states IDLE, NORMALIZE, ROUND, DONE; in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 In IDLE, in_valid&in_ready SHALL capture sign=in_data[MSB], an unsigned INTEGER_WIDTH-bit magnitude register = |in_data| (so -2^(W-1) is magnitude 2^(W-1)), and exp_cnt=INTEGER_WIDTH-1.
REQ-017 Zero capture SHALL go directly to DONE with out=all zeros (+0) and both flags 0.
REQ-018 Nonzero capture SHALL go to NORMALIZE.
REQ-019 In NORMALIZE, if magnitude MSB=1 the FSM SHALL go to ROUND; otherwise magnitude<<=1 and exp_cnt-=1, one bit per cycle.
REQ-020 In ROUND: mantissa = magnitude bits below the MSB, top MANTISSA_WIDTH bits, zero-padded on the right if fewer are available; guard = next bit; sticky = OR of all remaining bits.
REQ-021 In ROUND, inexact_flag = guard|sticky.
REQ-022 With ROUND_TO_NEAREST=1, the mantissa SHALL be incremented when guard&(sticky|mantissa[0]).
REQ-023 A mantissa carry-out SHALL clear the mantissa and increment exp_cnt.
REQ-024 Biased exponent SHALL be exp_cnt + (2^(EXPONENT_WIDTH-1)-1), computed EXPONENT_WIDTH+2 bits wide.
REQ-025 If the biased exponent >= all-ones, out SHALL be {sign, all-ones, zeros} with overflow_flag=1 and inexact_flag=1.
REQ-026 ROUND SHALL then go to DONE.
REQ-027 Latency from the acceptance edge: zero input SHALL give out_valid in the next cycle; nonzero input SHALL give out_valid 3+L cycles later, where L is the leading-zero count of the magnitude.
REQ-028 In DONE, out and flags SHALL be held stable while out_ready=0.
REQ-029 In DONE, out_ready=1 SHALL return the FSM to IDLE; a new input SHALL not be accepted in that same cycle.
REQ-030 out and flags SHALL be registered.

Reset
REQ-031 On rst=1 at a clock edge, the FSM SHALL go to IDLE, including mid-operation, and any in-flight conversion is discarded.
REQ-032 Reset values SHALL be in_ready=1, out_valid=0, out=0, inexact_flag=0, overflow_flag=0.
REQ-033 rst SHALL dominate in_valid in the same cycle.

Structure
REQ-034 Shared package float_pkg SHALL hold the FSM state encoding, the bias constant function, and the float field-width localparams.
REQ-035 The rounding step (REQ-020..025) SHALL be one combinational sub-module, round_to_nearest_even, instantiated once.

Verification (float32, INTEGER_WIDTH=32 unless stated)
REQ-036 1 -> out=0x3F800000, out_valid 34 cycles after accept, flags 0; -1 -> 0xBF800000.
REQ-037 0x80000000 -> 0xCF000000, exact, out_valid 3 cycles after accept; 0 -> 0x00000000 after 1 cycle.
REQ-038 16777217 -> 0x4B800000 with inexact=1; 16777219 -> 0x4B800002 with inexact=1 (ties to even); with ROUND_TO_NEAREST=0, 16777219 -> 0x4B800001.
REQ-039 EXPONENT_WIDTH=4, MANTISSA_WIDTH=3, INTEGER_WIDTH=16, input 0x4000 -> {0,1111,000}, overflow_flag=1.
REQ-040 Backpressure: out_ready held 0 for 10 cycles -> out stable and in_ready=0 throughout; on release, in_ready=1 in the next cycle.
REQ-041 Reset mid-NORMALIZE -> next cycle IDLE with out_valid=0 and in_ready=1; the following conversion is correct.
